// File: rtl/hash_key_checker.sv
// hash_key_checker
//   Read-side initiator for the write-protected key RAM. A requester presents
//   a candidate key. The block fetches the stored key from the protected slot
//   and compares the two in a fixed number of cycles, then returns pass/fail.
//   After MAX_FAILS consecutive failed compares it locks out until reset_n.
//   The stored key is never driven onto any output, and the RAM is never
//   written.
//
// Ports
//   clk            : clock, all state on rising edge
//   reset_n        : asynchronous reset, active-low
//   req_valid      : candidate key presented
//   req_ready      : request accepted this cycle (IDLE only)
//   req_key        : candidate key, sampled on handshake
//   resp_valid     : compare result available (held until resp_ready)
//   resp_ready     : requester consumes the result
//   resp_pass      : 1 = keys equal; 0 whenever resp_valid=0
//   locked         : lockout active, sticky until reset_n
//   fail_cnt       : current consecutive-failure count
//   mem_addr       : RAM byte address (KEY_ADDR during the fetch, else 0)
//   mem_write      : RAM write enable, constant 0
//   mem_write_data : RAM write data, constant 0
//   mem_data       : RAM read data, registered in the RAM (1-cycle latency)
module hash_key_checker #(
  parameter logic [31:0] KEY_ADDR  = 32'h0000_0000,
  parameter int          DATA_W    = 32,
  parameter int          MAX_FAILS = 3,
  parameter int          CNT_W     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_pass,
  output logic              locked,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [31:0]       mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data
);

  localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CMP,
    S_RESP,
    S_LOCKED
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  cand_p0;
  logic [DATA_W-1:0]  key_p1;
  logic               match_p2;
  logic [CNT_W-1:0]   fail_cnt_q;
  logic               match_c;

  // Failure counter increment that holds at the lockout limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = v;
    if (v != FAIL_LIMIT) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

  // Every bit is always folded in, so compare time is independent of where
  // (or whether) the keys differ.
  assign match_c = ~(|(cand_p0 ^ key_p1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_RD;
      S_RD:     state_d = S_WAIT;
      S_WAIT:   state_d = S_CMP;
      S_CMP:    state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_d = (fail_cnt_q == FAIL_LIMIT) ? S_LOCKED : S_IDLE;
        end
      end
      S_LOCKED: state_d = S_LOCKED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_p0    <= '0;
      key_p1     <= '0;
      match_p2   <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      case (state_q)
        // Stage 0: candidate captured on the request handshake
        S_IDLE: begin
          if (req_valid) cand_p0 <= req_key;
        end
        // Stage 1: RAM word arrives one cycle after the address was driven
        S_WAIT: begin
          key_p1 <= mem_data;
        end
        // Stage 2: compare result and failure count settle for RESP
        S_CMP: begin
          match_p2 <= match_c;
          if (match_c) begin
            fail_cnt_q <= '0;
          end else begin
            fail_cnt_q <= sat_inc(fail_cnt_q);
          end
        end
        // Scrub key material once the requester has the result
        S_RESP: begin
          if (resp_ready) begin
            cand_p0 <= '0;
            key_p1  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_RESP);
  assign resp_pass      = (state_q == S_RESP) & match_p2;
  assign locked         = (state_q == S_LOCKED);
  assign fail_cnt       = fail_cnt_q;
  assign mem_addr       = ((state_q == S_RD) || (state_q == S_WAIT)) ? KEY_ADDR : 32'h0;
  assign mem_write      = 1'b0;
  assign mem_write_data = '0;

endmodule
